// File: rtl/regfile_pkg.sv
// Shared defaults and address-width derivation for the scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;

  // Register index width; NREGS is a power of two no smaller than 2.
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register plus a live population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  parameter  int NWR   = NWR_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD-1:0]    rs_busy,
  output logic [AW:0]       busy_cnt
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_next;

  // Writes retire first, then the issue is applied so it wins on a collision.
  // NOTE: always_comb uses blocking '=' so later statements see earlier results;
  // registers below use '<=' so every flop samples pre-edge values.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (wa[j*AW +: AW] != '0)) busy_next[wa[j*AW +: AW]] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  // Busy lookup is purely from registered state: no same-cycle bypass.
  always_comb begin
    rs_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rs_busy[k] = busy[rs_addr[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with x0 hard-wired to zero and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  parameter  int NWR   = NWR_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs [NREGS];

  // NOTE: the array is reset because reset must clear every architectural
  // register; this forces flops rather than an inferred RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: ascending loop order makes the highest-index port the last
      // assignment, so it wins a same-address collision.
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wa[j*AW +: AW] != '0)) regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin : read_mux
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    rs_data = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rs_addr[k*AW +: AW];
      rd = (ra == '0) ? '0 : regs[ra];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wa[j*AW +: AW] == ra) && (ra != '0)) rd = wd[j*XLEN +: XLEN];
      end
`else
      // Without forwarding a written value appears one cycle after the edge.
`endif
      rs_data[k*XLEN +: XLEN] = rd;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .we        (we),
    .wa        (wa),
    .rs_addr   (rs_addr),
    .rs_busy   (rs_busy),
    .busy_cnt  (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Table-driven bench for regfile_sb (default 32x32, 2 read / 2 write ports),
// plus hand-written reset and forwarding sequences.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [2*AW-1:0]   rs_addr;
  logic [2*XLEN-1:0] rs_data;
  logic [1:0]        rs_busy;
  logic [1:0]        we;
  logic [2*AW-1:0]   wa;
  logic [2*XLEN-1:0] wd;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic [AW:0]       busy_cnt;

  int errors = 0;
  int checks = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_sb dut (
    .clk       (clk),
    .reset     (reset),
    .rs_addr   (rs_addr),
    .rs_data   (rs_data),
    .rs_busy   (rs_busy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic            iv;
    logic [AW-1:0]   ird;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] ed0, ed1;
    logic [1:0]      eb;
    logic [AW:0]     ec;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    we        = v.we;
    wa        = {v.wa1, v.wa0};
    wd        = {v.wd1, v.wd0};
    iss_valid = v.iv;
    iss_rd    = v.ird;
    rs_addr   = {v.ra1, v.ra0};
  endtask

  // Inputs held across one rising edge; outputs checked on the falling edge before it.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check({tag, " rs_data0"}, rs_data[31:0], v.ed0);
    check({tag, " rs_data1"}, rs_data[63:32], v.ed1);
    check({tag, " rs_busy"}, {30'd0, rs_busy}, {30'd0, v.eb});
    check({tag, " busy_cnt"}, {26'd0, busy_cnt}, {26'd0, v.ec});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //           we     wa0    wa1    wd0           wd1    iv    ird    ra0    ra1    ed0           ed1           eb     ec
    vecs[0]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 5'd0,  5'd5,  32'h0,        32'h0,        2'b00, 6'd0};
    vecs[1]  = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,  1'b0, 5'd0, 5'd1,  5'd2,  32'h0,        32'h0,        2'b00, 6'd0};
    vecs[2]  = '{2'b01, 5'd0,  5'd0,  32'h1234,     32'h0,  1'b0, 5'd0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
    vecs[3]  = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22, 1'b0, 5'd0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
    vecs[4]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b1, 5'd3, 5'd7,  5'd0,  32'h22,       32'h0,        2'b00, 6'd0};
    vecs[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 5'd3,  5'd7,  32'h0,        32'h22,       2'b01, 6'd1};
    vecs[6]  = '{2'b10, 5'd0,  5'd3,  32'h0,        32'h33, 1'b0, 5'd0, 5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 2'b00, 6'd1};
    vecs[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 5'd3,  5'd0,  32'h33,       32'h0,        2'b00, 6'd0};
    vecs[8]  = '{2'b01, 5'd3,  5'd0,  32'h44,       32'h0,  1'b1, 5'd3, 5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 2'b00, 6'd0};
    vecs[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 5'd3,  5'd3,  32'h44,       32'h44,       2'b11, 6'd1};
    vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b1, 5'd3, 5'd3,  5'd1,  32'h44,       32'h0,        2'b01, 6'd1};
    vecs[11] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 5'd1,  5'd3,  32'h0,        32'h44,       2'b10, 6'd1};
    vecs[12] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b1, 5'd0, 5'd0,  5'd3,  32'h0,        32'h44,       2'b10, 6'd1};
    vecs[13] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd1};
    vecs[14] = '{2'b11, 5'd8,  5'd8,  32'hAA,       32'hBB, 1'b0, 5'd0, 5'd3,  5'd7,  32'h44,       32'h22,       2'b01, 6'd1};
    vecs[15] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 5'd8,  5'd0,  32'hBB,       32'h0,        2'b00, 6'd1};
    vecs[16] = '{2'b10, 5'd0,  5'd3,  32'h0,        32'h55, 1'b0, 5'd0, 5'd8,  5'd7,  32'hBB,       32'h22,       2'b00, 6'd1};
    vecs[17] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,  1'b0, 5'd0, 5'd3,  5'd8,  32'h55,       32'hBB,       2'b00, 6'd0};

    reset = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Same-cycle write of 0xA5 to addr 9 while reading 9: forwarded or old value.
    v = '{2'b01, 5'd9, 5'd0, 32'hA5, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
          BYPASS ? 32'hA5 : 32'h0, BYPASS ? 32'hA5 : 32'h0, 2'b00, 6'd0};
    run_vec(v, "fwd_a5");
    // Two ports write addr 9 plus an issue to 9: port1 data forwarded, busy not bypassed.
    v = '{2'b11, 5'd9, 5'd9, 32'h1, 32'h2, 1'b1, 5'd9, 5'd9, 5'd0,
          BYPASS ? 32'h2 : 32'hA5, 32'h0, 2'b00, 6'd0};
    run_vec(v, "fwd_prio");
    v = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd1, 5'd9, 5'd5, 32'h2, 32'hDEADBEEF, 2'b01, 6'd1};
    run_vec(v, "iss1");
    v = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd2, 5'd1, 5'd9, 32'h0, 32'h2, 2'b11, 6'd2};
    run_vec(v, "iss2");
    v = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 5'd2, 5'd7, 32'h0, 32'h22, 2'b01, 6'd3};
    run_vec(v, "iss4");
    v = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd4, 32'hDEADBEEF, 32'h0, 2'b10, 6'd4};
    drive(v);
    @(negedge clk);
    check("pre_reset busy_cnt", {26'd0, busy_cnt}, 32'd4);
    check("pre_reset rs_busy", {30'd0, rs_busy}, 32'd2);

    // Asynchronous reset mid-cycle: no clock edge between assertion and checks.
    #1 reset = 1'b1;
    #1;
    check("async_rst rs_data0", rs_data[31:0], 32'h0);
    check("async_rst rs_busy", {30'd0, rs_busy}, 32'd0);
    check("async_rst busy_cnt", {26'd0, busy_cnt}, 32'd0);
    rs_addr = {5'd8, 5'd7};
    #1;
    check("async_rst reg7", rs_data[31:0], 32'h0);
    check("async_rst reg8", rs_data[63:32], 32'h0);

    // A write and issue presented across an edge during reset are discarded.
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'h99}; iss_valid = 1'b1; iss_rd = 5'd5;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    we = 2'b00; iss_valid = 1'b0; rs_addr = {5'd0, 5'd5};
    #1;
    check("rst_discard reg5", rs_data[31:0], 32'h0);
    check("rst_discard busy_cnt", {26'd0, busy_cnt}, 32'd0);

    // First edge after release accepts a write and a colliding issue (issue wins).
    we = 2'b01; wa = {5'd0, 5'd6}; wd = {32'h0, 32'h66}; iss_valid = 1'b1; iss_rd = 5'd6;
    @(posedge clk);
    #1;
    we = 2'b00; iss_valid = 1'b0; rs_addr = {5'd0, 5'd6};
    @(negedge clk);
    check("post_rst reg6", rs_data[31:0], 32'h66);
    check("post_rst rs_busy", {30'd0, rs_busy}, 32'd1);
    check("post_rst busy_cnt", {26'd0, busy_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of 2, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have port clk input 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port reset input 1, asynchronous, active-high reset.
REQ-007 SHALL have port rs_addr input NRD*AW, read addresses; port k in slice k.
REQ-008 SHALL have port rs_data output NRD*XLEN, read data per port.
REQ-009 SHALL have port rs_busy output NRD, scoreboard busy bit of each read address.
REQ-010 SHALL have port we input NWR, per-port write enable.
REQ-011 SHALL have port wa input NWR*AW, per-port write address.
REQ-012 SHALL have port wd input NWR*XLEN, per-port write data.
REQ-013 SHALL have port iss_valid input 1, issue strobe; marks iss_rd busy.
REQ-014 SHALL have port iss_rd input AW, destination register of the issued instruction.
REQ-015 SHALL have port busy_cnt output AW+1, number of registers currently busy.

Function
REQ-016 SHALL read combinationally: rs_data[k] = regs[rs_addr[k]]; address 0 always reads 0.
REQ-017 SHALL write regs[wa[j]] <= wd[j] on the clk edge when we[j]=1 and wa[j]!=0; writes to address 0 are discarded.
REQ-018 SHALL resolve same-cycle writes to the same address by priority: the highest-index port wins.
REQ-019 SHALL hold one busy bit per register; bit 0 is constant 0.
REQ-020 SHALL set busy[iss_rd] on the clk edge when iss_valid=1 and iss_rd!=0.
REQ-021 SHALL clear busy[wa[j]] on the clk edge when we[j]=1 and wa[j]!=0.
REQ-022 SHALL, when an issue and a write target the same register in one cycle, leave busy set (the issue wins).
REQ-023 SHALL drive rs_busy[k] = busy[rs_addr[k]] from registered state, with no bypass of same-cycle issue or write.
REQ-024 SHALL keep busy_cnt equal to the population count of busy, updated in the same edge as busy; setting an already-set bit does not change the count.

Reset
REQ-025 SHALL, while reset=1, asynchronously force all registers to 0, all busy bits to 0, and busy_cnt to 0.
REQ-026 SHALL discard any write or issue presented in the cycle reset is asserted; outstanding busy marks are lost.
REQ-027 SHALL accept writes and issues on the first clk edge after reset deasserts.

Configuration
REQ-028 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data to rs_data[k] when some we[j]=1 and wa[j]=rs_addr[k]!=0; the highest-index matching port wins. rs_busy is unaffected.
REQ-029 SHALL, without REGFILE_BYPASS_EN, return the pre-edge register content; the new value is visible one cycle after the write.

Structure
REQ-030 SHALL take the XLEN/NREGS defaults and the AW derivation from shared package regfile_pkg.
REQ-031 SHALL implement busy tracking and busy_cnt in sub-module regfile_scoreboard, instanced once.

Verification
REQ-032 SHALL cover write port0 addr 5 = 0xDEADBEEF, then read port1 addr 5 on the next cycle -> 0xDEADBEEF; write addr 0 = 0x1234 -> reads 0.
REQ-033 SHALL cover port0 and port1 both writing addr 7 (0x11, 0x22) in one cycle -> addr 7 reads 0x22.
REQ-034 SHALL cover issue rd=3 -> rs_busy=1 and busy_cnt=1; write addr 3 -> busy clears and busy_cnt=0; issue rd=3 with a same-cycle write to 3 -> busy stays 1.
REQ-035 SHALL cover a same-cycle write of 0xA5 to addr 9 while reading addr 9 -> 0xA5 with REGFILE_BYPASS_EN defined, and the old value without it.
REQ-036 SHALL cover issuing rd=1,2,4, then asserting reset mid-stream -> all reads 0, busy_cnt=0, with no clk edge required.
